cvt_7to1_ascii: RTL and testbench

CVT_7TO1_ASCII -- requirements
Module: cvt_7to1_ascii

---
 rtl/cvt_7to1_ascii.sv | 154 +++++++++++++++
 tb/tb_cvt_7to1_ascii.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvt_7to1_ascii.sv
// cvt_7to1_ascii: buffered 7-bit ASCII to serial converter.
// Characters enter a FIFO and leave MSB first on sout. Frames run back to
// back with no gap while the FIFO holds data.
// Optional: define CVT_7TO1_PARITY_EN to append an even-parity bit and
// make each frame 8 bits long.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   din, din_valid : character offered, accepted when din_ready=1
//   din_ready      : FIFO has room (low while rst)
//   sout           : serial data, sout_valid marks frame bits
//   sof            : first bit of each frame
//   idle           : FIFO empty and no frame in progress
//   level          : characters waiting in the FIFO
module cvt_7to1_ascii #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          sout,
  output logic                          sout_valid,
  output logic                          sof,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef CVT_7TO1_PARITY_EN
  localparam int FRAME = 8;
`else
  localparam int FRAME = 7;
`endif
  localparam int CW = $clog2(FRAME);

  localparam logic [LW-1:0] FULL_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [6:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [6:0]       head;
  logic [FRAME-1:0] frame;
  logic             push;
  logic             pop;
  logic             has_data;
  logic             last_bit;

  assign head = mem[rd_ptr];

`ifdef CVT_7TO1_PARITY_EN
  assign frame = {head, ^head};
`else
  assign frame = head;
`endif

  assign has_data = (count != '0);
  assign last_bit = (bit_cnt == LAST_C);

  // Ready depends only on stored level, so a pop on a full FIFO
  // does not open a slot in the same cycle.
  assign din_ready = ~rst & (count < FULL_L);
  assign push      = din_valid & din_ready;

  // Shifter loads whenever it is free or finishing its last bit.
  assign pop = has_data & ((state == IDLE) | last_bit);

  assign level = count;
  assign idle  = (state == IDLE) & ~has_data;
  assign sout  = shreg[FRAME-1];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Shift register is cleared on leaving a frame so sout reads 0
  // whenever sout_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (has_data) begin
            state      <= SHIFT;
            shreg      <= frame;
            bit_cnt    <= '0;
            sout_valid <= 1'b1;
            sof        <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg   <= {shreg[FRAME-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_ONE;
            sof     <= 1'b0;
          end else if (has_data) begin
            shreg      <= frame;
            bit_cnt    <= '0;
            sout_valid <= 1'b1;
            sof        <= 1'b1;
          end else begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvt_7to1_ascii.sv
// tb_cvt_7to1_ascii: self-checking bench for cvt_7to1_ascii.
// Frame-level stream model plus directed and random stimulus.
module tb_cvt_7to1_ascii;

  localparam int DEPTH = 4;
`ifdef CVT_7TO1_PARITY_EN
  localparam int FRAME = 8;
`else
  localparam int FRAME = 7;
`endif

  logic                     clk;
  logic                     rst;
  logic [6:0]               din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     sout;
  logic                     sout_valid;
  logic                     sof;
  logic                     idle;
  logic [$clog2(DEPTH):0]   level;

  cvt_7to1_ascii #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sof        (sof),
    .idle       (idle),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit b;
    bit s;
  } bit_t;

  bit_t       exp_q[$];
  int         lvl_m     = 0;
  int         rem_m     = 0;
  bit         exp_start = 1'b0;
  bit         pend_rst  = 1'b1;
  bit         pend_acc  = 1'b0;
  logic [6:0] pend_ch   = '0;
  int         cyc       = 0;

  bit         cap_en  = 1'b0;
  bit         cap_b[$];
  bit         cap_s[$];
  int         cap_c[$];
  int         max_lvl = 0;

  function automatic bit par_of(input logic [6:0] c);
    return ($countones(c) % 2) == 1;
  endfunction

  function automatic void push_frame(input logic [6:0] c);
    for (int j = 6; j >= 0; j--) begin
      exp_q.push_back('{b: c[j], s: (j == 6)});
    end
`ifdef CVT_7TO1_PARITY_EN
    exp_q.push_back('{b: par_of(c), s: 1'b0});
`endif
  endfunction

  function automatic logic [7:0] frame_of(input logic [6:0] c);
`ifdef CVT_7TO1_PARITY_EN
    return {c, par_of(c)};
`else
    return {1'b0, c};
`endif
  endfunction

  // Inputs are driven 1ns after posedge, so the values seen here are
  // the ones the next edge will sample.
  always @(negedge clk) begin
    bit   ev;
    bit_t h;
    cyc++;
    if (pend_rst) begin
      exp_q.delete();
      lvl_m     = 0;
      rem_m     = 0;
      exp_start = 1'b0;
    end else if (pend_acc) begin
      push_frame(pend_ch);
      lvl_m++;
    end
    ev = exp_start || (rem_m > 0);
    check("sout_valid", 32'(sout_valid), 32'(ev));
    if (ev) begin
      h = '{b: 1'b0, s: 1'b0};
      if (exp_q.size() > 0) h = exp_q.pop_front();
      check("sout", 32'(sout), 32'(h.b));
      check("sof", 32'(sof), 32'(h.s));
      if (h.s) begin
        lvl_m--;
        rem_m = FRAME - 1;
      end else if (rem_m > 0) begin
        rem_m--;
      end
    end else begin
      check("sout_sof_quiet", 32'({sout, sof}), 32'(0));
    end
    check("level", 32'(level), 32'(lvl_m));
    check("idle", 32'(idle), 32'(!ev && lvl_m == 0));
    check("din_ready", 32'(din_ready), 32'(!rst && lvl_m < DEPTH));
    exp_start = (rem_m == 0) && (lvl_m > 0);
    if (cap_en) begin
      if (32'(level) > max_lvl) max_lvl = 32'(level);
      if (sout_valid === 1'b1) begin
        cap_b.push_back(sout);
        cap_s.push_back(sof);
        cap_c.push_back(cyc);
      end
    end
    pend_rst = rst;
    pend_acc = !rst && din_valid && (lvl_m < DEPTH);
    pend_ch  = din;
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while (!(idle === 1'b1 && sout_valid === 1'b0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= budget) begin
      n_fail++;
      $display("FAIL wait_idle: idle=%b after %0d cycles, want 1",
               idle, budget);
    end
  endtask

  task automatic drive_str(input string s, input int budget);
    int i = 0;
    int t = 0;
    bit acc;
    @(posedge clk); #1;
    din       = 7'(s[0]);
    din_valid = 1'b1;
    while (i < s.len() && t < budget) begin
      @(negedge clk);
      acc = (din_ready === 1'b1);
      @(posedge clk); #1;
      t++;
      if (acc) begin
        i++;
        if (i < s.len()) din = 7'(s[i]);
        else din_valid = 1'b0;
      end
    end
    n_tests++;
    if (i < s.len()) begin
      n_fail++;
      din_valid = 1'b0;
      $display("FAIL drive_str: %0d of %0d chars accepted", i, s.len());
    end
  endtask

  function automatic void cap_clear();
    cap_b.delete();
    cap_s.delete();
    cap_c.delete();
    max_lvl = 0;
  endfunction

  task automatic check_capture(input string s, input string tag);
    int n;
    logic [7:0] v;
    logic [7:0] sv;
    n = s.len() * FRAME;
    check({tag, "_bits"}, 32'(cap_b.size()), 32'(n));
    if (cap_c.size() > 0) begin
      check({tag, "_contig"}, 32'(cap_c[$] - cap_c[0]),
            32'(cap_c.size() - 1));
    end
    for (int c = 0; c < s.len(); c++) begin
      if ((c + 1) * FRAME <= cap_b.size()) begin
        v  = '0;
        sv = '0;
        for (int j = 0; j < FRAME; j++) begin
          v  = {v[6:0], cap_b[c * FRAME + j]};
          sv = {sv[6:0], cap_s[c * FRAME + j]};
        end
        check({tag, "_char"}, 32'({sv, v}),
              32'({8'(1) << (FRAME - 1), frame_of(7'(s[c]))}));
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [6:0] ch;
    logic [6:0] bits;
    logic       par;
  } vec_t;

  vec_t vt[7];

  task automatic send_one(input vec_t v);
    logic eb;
    wait_idle(60);
    @(posedge clk); #1;
    din       = v.ch;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din       = 7'($urandom);
    @(negedge clk);
    check("lat_pre_valid", 32'(sout_valid), 32'(0));
    check("lat_pre_level", 32'(level), 32'(1));
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      eb = (i < 7) ? v.bits[6 - i] : v.par;
      check("vec_valid", 32'(sout_valid), 32'(1));
      check("vec_bit", 32'(sout), 32'(eb));
      check("vec_sof", 32'(sof), 32'(i == 0));
    end
    @(negedge clk);
    check("vec_end_idle", 32'({idle, sout_valid}), 32'(2'b10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{ch: 7'h41, bits: 7'b1000001, par: 1'b0};
    vt[1] = '{ch: 7'h43, bits: 7'b1000011, par: 1'b1};
    vt[2] = '{ch: 7'h00, bits: 7'b0000000, par: 1'b0};
    vt[3] = '{ch: 7'h7F, bits: 7'b1111111, par: 1'b1};
    vt[4] = '{ch: 7'h55, bits: 7'b1010101, par: 1'b0};
    vt[5] = '{ch: 7'h2A, bits: 7'b0101010, par: 1'b1};
    vt[6] = '{ch: 7'h61, bits: 7'b1100001, par: 1'b1};

    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'({sout_valid, sof, sout, idle, din_ready}),
          32'(5'b00010));
    check("rst_level", 32'(level), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 32'({din_ready, idle}), 32'(2'b11));

    for (int i = 0; i < 6; i++) send_one(vt[i]);

    // continuous stream with din_valid held high
    wait_idle(60);
    cap_clear();
    cap_en = 1'b1;
    drive_str("Hello_World+", 400);
    wait_idle(300);
    cap_en = 1'b0;
    check_capture("Hello_World+", "stream");
    check("stream_max_level", 32'(max_lvl), 32'(DEPTH));

    // reset during bit 3 of 'W' with two characters queued
    wait_idle(60);
    drive_str("Wxy", 20);
    @(negedge clk);
    check("rstmid_queued", 32'(level), 32'(2));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'({sout_valid, sof}), 32'(2'b10));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_after", 32'({sout_valid, idle, level}),
          32'({1'b0, 1'b1, 3'd0}));
    @(negedge clk);
    check("rstmid_no_resume", 32'({sout_valid, idle, din_ready}),
          32'(3'b011));
    send_one(vt[6]);

`ifdef CVT_7TO1_PARITY_EN
    wait_idle(60);
    cap_clear();
    cap_en = 1'b1;
    drive_str("CA", 20);
    wait_idle(60);
    cap_en = 1'b0;
    check_capture("CA", "parity");
    if (cap_b.size() == 16) begin
      logic [15:0] pv;
      pv = '0;
      for (int j = 0; j < 16; j++) pv = {pv[14:0], cap_b[j]};
      check("parity_ca", 32'(pv), 32'(16'b1000011_1_1000001_0));
    end
`endif

    // random traffic with occasional resets
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 249) == 0);
      din_valid = ($urandom_range(0, 9) < ((c < 450) ? 8 : 2));
      din       = 7'($urandom);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    wait_idle(200);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
